nibble_deserializer: RTL and testbench

NIBBLE_DESERIALIZER -- requirements
Module: nibble_deserializer

---
 rtl/nibble_deserializer.sv | 121 ++++++++++++
 tb/tb_nibble_deserializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_deserializer.sv
// Serial-to-nibble capture with start-edge framing, overrun detection and a timed HOLD window.
// All signals are multiplexed onto the io_in/io_out byte ports.
module nibble_deserializer #(
   parameter int unsigned HOLD_CYCLES = 15
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES);

   typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

   logic clk, rst_n, ser_data, ser_valid, start, mode, invert, hold_clear;
   assign clk        = io_in[0];
   assign rst_n      = io_in[1];
   assign ser_data   = io_in[2];
   assign ser_valid  = io_in[3];
   assign start      = io_in[4];
   assign mode       = io_in[5];
   assign invert     = io_in[6];
   assign hold_clear = io_in[7];

   state_e      state_q, state_d;
   logic [3:0]  sr_q, sr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        mode_q, mode_d;
   logic [3:0]  out_q, out_d;
   logic        par_q, par_d;
   logic        ovr_q, ovr_d;
   logic [7:0]  hold_q, hold_d;
   logic        start_q;
   logic        start_edge;
   logic [3:0]  sr_shift;

   assign start_edge = start & ~start_q;
   assign sr_shift   = mode_q ? {ser_data, sr_q[3:1]} : {sr_q[2:0], ser_data};

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      out_d   = out_q;
      par_d   = par_q;
      hold_d  = hold_q;
      ovr_d   = hold_clear ? 1'b0 : ovr_q;

      unique case (state_q)
         StIdle: begin
            if (start_edge) begin
               state_d = StShift;
               sr_d    = 4'd0;
               cnt_d   = 2'd0;
               mode_d  = mode;
            end
         end
         StShift: begin
            if (start_edge) begin
               // Restart the frame; any bit presented this cycle is dropped.
               ovr_d  = 1'b1;
               sr_d   = 4'd0;
               cnt_d  = 2'd0;
               mode_d = mode;
            end else if (ser_valid) begin
               sr_d  = sr_shift;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  out_d   = sr_shift;
                  par_d   = ^sr_shift;
                  hold_d  = HoldLoad;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (start_edge) begin
               state_d = StShift;
               sr_d    = 4'd0;
               cnt_d   = 2'd0;
               mode_d  = mode;
            end else if (hold_clear) begin
               state_d = StIdle;
            end else if (hold_q <= 8'd1) begin
               state_d = StIdle;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sr_q    <= 4'd0;
         cnt_q   <= 2'd0;
         mode_q  <= 1'b0;
         out_q   <= 4'd0;
         par_q   <= 1'b0;
         ovr_q   <= 1'b0;
         hold_q  <= 8'd0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
         par_q   <= par_d;
         ovr_q   <= ovr_d;
         hold_q  <= hold_d;
         start_q <= start;
      end
   end

   assign io_out = {par_q, ovr_q, state_q == StHold, state_q == StShift,
                    out_q ^ {4{invert}}};

endmodule

// File: tb/tb_nibble_deserializer.sv
// Self-checking bench: directed frames plus random traffic against a frame-level reference model.
module tb_nibble_deserializer;

   localparam int HoldCycles = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ser_data = 1'b0, ser_valid = 1'b0, start = 1'b0, mode = 1'b0;
   logic invert = 1'b0, hold_clear = 1'b0;
   logic [7:0] io_in, io_out;

   assign io_in = {hold_clear, invert, mode, start, ser_valid, ser_data, rst_n, clk};

   nibble_deserializer #(.HOLD_CYCLES(HoldCycles)) dut (
      .io_in (io_in),
      .io_out(io_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase 0=idle 1=collecting 2=holding; bits kept in arrival order.
   int   m_phase;
   bit   m_bits[$];
   bit   m_mode, m_par, m_ovr, m_start_prev;
   int   m_nib;
   int   m_hold_left;

   task automatic model_reset();
      m_phase = 0; m_bits.delete(); m_mode = 0; m_par = 0; m_ovr = 0;
      m_start_prev = 0; m_nib = 0; m_hold_left = 0;
   endtask

   task automatic model_begin_frame();
      m_phase = 1; m_bits.delete(); m_mode = mode;
   endtask

   task automatic model_step();
      bit st_edge;
      int ph, v;
      if (!rst_n) begin
         model_reset();
         return;
      end
      st_edge = start && !m_start_prev;
      m_start_prev = start;
      ph = m_phase;
      if (ph == 1 && st_edge) m_ovr = 1;
      else if (hold_clear) m_ovr = 0;
      case (ph)
         0: if (st_edge) model_begin_frame();
         1: begin
            if (st_edge) model_begin_frame();
            else if (ser_valid) begin
               m_bits.push_back(ser_data);
               if (m_bits.size() == 4) begin
                  v = 0;
                  for (int i = 0; i < 4; i++)
                     v += m_mode ? (int'(m_bits[i]) << i) : (int'(m_bits[i]) << (3 - i));
                  m_nib = v;
                  m_par = ($countones(v) % 2) == 1;
                  m_phase = 2;
                  m_hold_left = HoldCycles;
               end
            end
         end
         default: begin
            if (st_edge) model_begin_frame();
            else if (hold_clear) m_phase = 0;
            else begin
               m_hold_left--;
               if (m_hold_left == 0) m_phase = 0;
            end
         end
      endcase
   endtask

   function automatic logic [7:0] model_out();
      logic [3:0] n;
      n = 4'(m_nib) ^ {4{invert}};
      return {m_par, m_ovr, m_phase == 2, m_phase == 1, n};
   endfunction

   // One clock: model follows the edge, outputs compared 1 time unit later, return at negedge.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_eq(tag, io_out, model_out());
      @(negedge clk);
   endtask

   task automatic pulse_start(input bit m);
      mode = m; start = 1; tick("start");
      start = 0;
   endtask

   task automatic send_bit(input bit b);
      ser_valid = 1; ser_data = b; tick("bit");
      ser_valid = 0;
   endtask

   task automatic assert_reset();
      rst_n = 0;
      #1;
      model_reset();
      check_eq("async_reset", io_out, model_out());
      tick("in_reset");
      rst_n = 1;
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      #1;
      check_eq("reset_out", io_out, 8'h00);
      invert = 1; #1;
      check_eq("reset_inv", io_out, 8'h0F);
      invert = 0;
      tick("reset_hold");
      rst_n = 1;

      // MSB-first 1,0,1,1
      pulse_start(0);
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      #1;
      check_eq("msb_nib", {4'h0, io_out[3:0]}, 8'h0B);
      check_eq("msb_flags", {4'h0, io_out[7:4]}, 8'b1010);
      // Done lasts HoldCycles samples, then idle with value retained.
      tick("hold2"); tick("hold3");
      #1; check_eq("still_done", {7'd0, io_out[5]}, 8'd1);
      tick("hold_exit");
      #1; check_eq("timeout_idle", io_out, 8'h8B);

      // LSB-first 1,0,1,1, then invert
      pulse_start(1);
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      #1; check_eq("lsb_nib", {4'h0, io_out[3:0]}, 8'h0D);
      invert = 1; #1;
      check_eq("lsb_inv", io_out, 8'b1010_0010);
      invert = 0;
      hold_clear = 1; tick("hold_clear_exit"); hold_clear = 0;

      // Gapped valid
      pulse_start(0);
      for (int i = 0; i < 7; i++) begin
         ser_valid = (i % 2 == 0); ser_data = (i == 2) ? 1'b0 : 1'b1;
         tick("gap");
         if (i < 6) check_eq("gap_busy", {7'd0, io_out[4]}, 8'd1);
      end
      ser_valid = 0;
      check_eq("gap_nib", io_out, 8'hAB);

      // Overrun: restart after two bits
      pulse_start(0);
      send_bit(1); send_bit(1);
      pulse_start(0);
      send_bit(0); send_bit(1); send_bit(1); send_bit(0);
      #1; check_eq("ovr_out", io_out, 8'b0110_0110);
      hold_clear = 1; tick("ovr_clear"); hold_clear = 0;
      #1; check_eq("ovr_cleared", {7'd0, io_out[6]}, 8'd0);

      // Reset mid-frame after three bits
      pulse_start(0);
      send_bit(1); send_bit(1); send_bit(1);
      assert_reset();
      check_eq("rst_mid", io_out, 8'h00);
      pulse_start(1);
      send_bit(0); send_bit(0); send_bit(1); send_bit(0);
      #1; check_eq("post_rst_nib", io_out, 8'b1010_0100);

      // Start already high across reset release counts as an edge
      start = 1; rst_n = 0; #1; model_reset();
      tick("rst_start_hi");
      rst_n = 1;
      tick("rst_release_edge");
      start = 0;
      check_eq("edge_after_rst", {7'd0, io_out[4]}, 8'd1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         start      = ($urandom_range(0, 9) == 0);
         ser_valid  = ($urandom_range(0, 3) != 0);
         ser_data   = 1'($urandom);
         mode       = 1'($urandom);
         invert     = 1'($urandom);
         hold_clear = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 149) == 0) assert_reset();
         else tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
